multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the RiskV multicycle core, sitting directly upstream of the `alu`. It sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the ALU opcode, the ALU operand selects, the datapath register enables and the memory strobes. It consumes the ALU `zero`/`sign` flags to resolve branches. Memory accesses use a ready handshake, so slow memory stalls the FSM.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- sign  in  1  ALU sign flag (aluResult[31])
- memReady  in  1  memory completes current access this cycle
- pcWrite  out  1  PC register enable
- irWrite  out  1  IR/oldPC register enable
- regWrite  out  1  register-file write enable
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- aluSrcA  out  2  ALU operand A select: 00 = PC, 01 = oldPC, 10 = rs1
- aluSrcB  out  2  ALU operand B select: 00 = rs2, 01 = imm, 10 = constant 4
- resultSrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J; combinational from `op`
- aluControl  out  3  ALU opcode: 000 = ADD, 001 = SLL, 010 = SUB, 100 = XOR, 101 = SRL, 110 = OR, 111 = AND
- illegal  out  1  sticky illegal-instruction flag

## Operation
- Only the state register is sequential; all outputs are a combinational decode of state, `op`, `funct3` and `funct7b5`.
- Unlisted outputs default to 0.
- FETCH:
  - Drives memRead=1, adrSrc=0.
  - Holds until memReady=1.
  - In the memReady cycle: irWrite=1, pcWrite=1, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10. Then goes to DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, ADD (precomputes the branch/jump target). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → unsupported
- MEMADR: aluSrcA=10, aluSrcB=01, ADD. Goes to MEMREAD for load, MEMWRITE for store.
- MEMREAD: adrSrc=1, memRead=1; holds until memReady=1, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1, then FETCH.
- MEMWRITE: adrSrc=1, memWrite=1; holds until memReady=1, then FETCH.
- EXECR: aluSrcA=10, aluSrcB=00. EXECI: aluSrcA=10, aluSrcB=01. Both go to ALUWB.
- ALU decode by funct3 (EXECR/EXECI only):
  - 000 → ADD; SUB only when EXECR and funct7b5=1
  - 001 → SLL
  - 100 → XOR
  - 101 → SRL (SRA/SRAI execute as SRL)
  - 110 → OR
  - 111 → AND
  - 010, 011 → unsupported
- ALUWB: resultSrc=00, regWrite=1, then FETCH.
- BRANCH:
  - aluSrcA=10, aluSrcB=00, SUB, resultSrc=00.
  - pcWrite = taken: funct3 000 on zero, 001 on !zero, 100 on sign, 101 on !sign.
  - Other funct3 values are never taken.
  - BLT/BGE use the sign of the difference; overflow is ignored.
  - Then FETCH.
- JAL: aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWrite=1, then ALUWB (writes rd = oldPC+4).

## Timing
- While rst_n=0:
  - State is FETCH.
  - pcWrite, irWrite, regWrite, memRead, memWrite and illegal are all 0.
  - Selects hold their FETCH values: adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10, aluControl=000.
- Reset asserted mid-instruction takes effect asynchronously and the transaction is abandoned. memWrite drops in the same cycle.
- First memRead occurs in the first cycle after rst_n deasserts.
- Cycle counts with memReady constantly 1: load 5; store, R-type, I-type and JAL 4; branch 3.
- Each cycle with memReady=0 adds one cycle. During the stall, strobes, adrSrc and state are held stable.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.

## Configuration
- `RISKV_ILLEGAL_TRAP_EN` defined:
  - An unsupported op in DECODE, or unsupported funct3 in EXECR/EXECI, enters state ILLEGAL.
  - ILLEGAL sets illegal=1 with all strobes 0.
  - Only reset exits ILLEGAL.
- Macro undefined:
  - An unsupported op goes DECODE → FETCH as a NOP.
  - Unsupported funct3 goes EXECR/EXECI → FETCH without regWrite.
  - illegal is tied to 0 and the ILLEGAL state is not built.

## Structure
- Package `riskv_pkg` holds:
  - state enum
  - ALU opcode constants (ALU_ADD … ALU_AND), shared with `alu`
  - opcode constants
  - aluSrcA/aluSrcB/resultSrc/immSrc encodings
- One sub-module, `alu_decoder`: maps funct3/funct7b5/R-vs-I to aluControl plus a `valid` flag.

## Test plan
- Reset, then R-type `sub` (funct7b5=1), memReady=1 → states FETCH, DECODE, EXECR, ALUWB. aluControl=010 in EXECR, regWrite only in ALUWB, 4 cycles total.
- `lw` with memReady low for 3 cycles in both FETCH and MEMREAD → 11 cycles total. memRead and adrSrc stable through each stall; regWrite with resultSrc=01 exactly once.
- `beq` with zero=1 → pcWrite in BRANCH. With zero=0 → no pcWrite. `blt` with sign=1 → taken.
- rst_n pulled low during MEMWRITE with memReady=0 → memWrite falls immediately. After release, the FSM restarts in FETCH with memRead=1.
- Opcode 0000000 → with `RISKV_ILLEGAL_TRAP_EN`: illegal=1, no strobes, stuck until reset. Without it: returns to FETCH after DECODE.
- `slti` (funct3 010) → treated as unsupported per the configuration. `srai` → aluControl=101.

Source files
------------

// File: rtl/riskv_pkg.sv
// Shared encodings for the RiskV multicycle core: FSM states, ALU opcodes, opcodes and mux selects.
// The ILLEGAL state exists only when RISKV_ILLEGAL_TRAP_EN is defined.
package riskv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
`ifdef RISKV_ILLEGAL_TRAP_EN
        , S_ILLEGAL
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from funct3/funct7b5 for register and immediate arithmetic.
// Purely combinational; valid=0 flags funct3 encodings this core does not implement.
module alu_decoder
    import riskv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [2:0] alu_ctrl_o,
    output logic       valid_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct3_i)
            3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl_o = ALU_SLL;
            3'b100:  alu_ctrl_o = ALU_XOR;
            // Arithmetic right shifts fall back to logical: the ALU has no SRA.
            3'b101:  alu_ctrl_o = ALU_SRL;
            3'b110:  alu_ctrl_o = ALU_OR;
            3'b111:  alu_ctrl_o = ALU_AND;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the RiskV multicycle core; outputs are a combinational decode of state and instruction.
// Optional trap on unsupported instructions under RISKV_ILLEGAL_TRAP_EN; memory stalls on memReady=0.
module multicycle_control
    import riskv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       sign,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       adrSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [2:0] dec_alu;
    logic       dec_valid;
    logic       is_rtype;
    logic       taken;
    logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, ill;

    assign is_rtype = (state_q == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .is_rtype_i (is_rtype),
        .alu_ctrl_o (dec_alu),
        .valid_o    (dec_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = sign;
            3'b101:  taken = !sign;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  immSrc = IMM_S;
            OP_BRANCH: immSrc = IMM_B;
            OP_JAL:    immSrc = IMM_J;
            default:   immSrc = IMM_I;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ill        = 1'b0;
        adrSrc     = 1'b0;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_RS2;
        resultSrc  = RES_ALUOUT;
        aluControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                if (memReady) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
`ifdef RISKV_ILLEGAL_TRAP_EN
                    default:           state_d = S_ILLEGAL;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                mem_rd = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = RES_RDATA;
                reg_wr    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc = 1'b1;
                mem_wr = 1'b1;
                if (memReady) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                aluControl = dec_alu;
`ifdef RISKV_ILLEGAL_TRAP_EN
                state_d    = dec_valid ? S_ALUWB : S_ILLEGAL;
`else
                state_d    = dec_valid ? S_ALUWB : S_FETCH;
`endif
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = SRCA_RS1;
                aluControl = ALU_SUB;
                pc_wr      = taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                pc_wr   = 1'b1;
                state_d = S_ALUWB;
            end
`ifdef RISKV_ILLEGAL_TRAP_EN
            S_ILLEGAL: begin
                ill = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces FETCH, whose read strobe must still be suppressed while rst_n is low.
    assign pcWrite  = pc_wr  & rst_n;
    assign irWrite  = ir_wr  & rst_n;
    assign regWrite = reg_wr & rst_n;
    assign memRead  = mem_rd & rst_n;
    assign memWrite = mem_wr & rst_n;

`ifdef RISKV_ILLEGAL_TRAP_EN
    assign illegal = ill & rst_n;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand sequences for reset and trap cases.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, sign, memReady;
    logic       pcWrite, irWrite, regWrite, memRead, memWrite, adrSrc, illegal;
    logic [1:0] aluSrcA, aluSrcB, resultSrc, immSrc;
    logic [2:0] aluControl;

    int nchk = 0;
    int nerr = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .sign(sign), .memReady(memReady),
        .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite), .memRead(memRead),
        .memWrite(memWrite), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .resultSrc(resultSrc), .immSrc(immSrc), .aluControl(aluControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected vector: {pc,ir,rw,mr,mw,adr, srcA, srcB, res, alu, illegal}
    localparam logic [15:0] O_RST = {6'b000000, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] O_FW  = {6'b000100, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] O_FR  = {6'b110100, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [15:0] O_DEC = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_MA  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_MR  = {6'b000101, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_MWB = {6'b001000, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0};
    localparam logic [15:0] O_MW  = {6'b000011, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_AWB = {6'b001000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_JAL = {6'b100000, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] O_ILL = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    function automatic logic [15:0] exr(input logic [2:0] alu);
        return {6'b000000, 2'b10, 2'b00, 2'b00, alu, 1'b0};
    endfunction
    function automatic logic [15:0] exi(input logic [2:0] alu);
        return {6'b000000, 2'b10, 2'b01, 2'b00, alu, 1'b0};
    endfunction
    function automatic logic [15:0] brn(input logic t);
        return {t, 5'b00000, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0};
    endfunction
    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, s, rdy;
        logic [15:0] exp;
    } row_t;

    row_t tbl[$];

    function automatic row_t r(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic s, input logic rdy,
                               input logic [15:0] e);
        row_t x;
        x.rst = rst; x.op = o; x.f3 = f3; x.f7 = f7; x.z = z; x.s = s; x.rdy = rdy; x.exp = e;
        return x;
    endfunction

    task automatic check(input string nm, input logic [15:0] e);
        logic [17:0] act, req;
        act = {pcWrite, irWrite, regWrite, memRead, memWrite, adrSrc, aluSrcA, aluSrcB,
               resultSrc, aluControl, illegal, immSrc};
        req = {e, imm_of(op)};
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %b required %b", nm, act, req);
        end
    endtask

    task automatic step(input row_t x, input string nm);
        @(posedge clk);
        #1;
        rst_n = x.rst; op = x.op; funct3 = x.f3; funct7b5 = x.f7;
        zero = x.z; sign = x.s; memReady = x.rdy;
        @(negedge clk);
        check(nm, x.exp);
    endtask

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; sign = 1'b0; memReady = 1'b0;

        tbl.push_back(r(0, 7'd0, 3'b000, 0, 0, 0, 1, O_RST));
        tbl.push_back(r(0, 7'd0, 3'b000, 0, 0, 0, 1, O_RST));
        // sub: 4 cycles, SUB in EXECR
        tbl.push_back(r(1, RT, 3'b000, 1, 0, 0, 1, O_FR));
        tbl.push_back(r(1, RT, 3'b000, 1, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, RT, 3'b000, 1, 0, 0, 1, exr(3'b010)));
        tbl.push_back(r(1, RT, 3'b000, 1, 0, 0, 1, O_AWB));
        // xor
        tbl.push_back(r(1, RT, 3'b100, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, RT, 3'b100, 0, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, RT, 3'b100, 0, 0, 0, 1, exr(3'b100)));
        tbl.push_back(r(1, RT, 3'b100, 0, 0, 0, 1, O_AWB));
        // lw with 3 stall cycles in FETCH and in MEMREAD: 11 cycles
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_FW));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_FW));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_FW));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_DEC));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_MA));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_MR));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_MR));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 0, O_MR));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 1, O_MR));
        tbl.push_back(r(1, LD, 3'b010, 0, 0, 0, 1, O_MWB));
        // sw
        tbl.push_back(r(1, ST, 3'b010, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, ST, 3'b010, 0, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, ST, 3'b010, 0, 0, 0, 1, O_MA));
        tbl.push_back(r(1, ST, 3'b010, 0, 0, 0, 1, O_MW));
        // srai executes as SRL
        tbl.push_back(r(1, IT, 3'b101, 1, 0, 0, 1, O_FR));
        tbl.push_back(r(1, IT, 3'b101, 1, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, IT, 3'b101, 1, 0, 0, 1, exi(3'b101)));
        tbl.push_back(r(1, IT, 3'b101, 1, 0, 0, 1, O_AWB));
        // addi with funct7b5 set stays ADD
        tbl.push_back(r(1, IT, 3'b000, 1, 0, 0, 1, O_FR));
        tbl.push_back(r(1, IT, 3'b000, 1, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, IT, 3'b000, 1, 0, 0, 1, exi(3'b000)));
        tbl.push_back(r(1, IT, 3'b000, 1, 0, 0, 1, O_AWB));
        // branches
        tbl.push_back(r(1, BR, 3'b000, 0, 1, 0, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b000, 0, 1, 0, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b000, 0, 1, 0, 1, brn(1)));
        tbl.push_back(r(1, BR, 3'b000, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b000, 0, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b000, 0, 0, 0, 1, brn(0)));
        tbl.push_back(r(1, BR, 3'b100, 0, 0, 1, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b100, 0, 0, 1, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b100, 0, 0, 1, 1, brn(1)));
        tbl.push_back(r(1, BR, 3'b101, 0, 0, 1, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b101, 0, 0, 1, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b101, 0, 0, 1, 1, brn(0)));
        tbl.push_back(r(1, BR, 3'b001, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b001, 0, 0, 0, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b001, 0, 0, 0, 1, brn(1)));
        tbl.push_back(r(1, BR, 3'b010, 0, 1, 1, 1, O_FR));
        tbl.push_back(r(1, BR, 3'b010, 0, 1, 1, 1, O_DEC));
        tbl.push_back(r(1, BR, 3'b010, 0, 1, 1, 1, brn(0)));
        // jal, memReady low outside memory states is ignored
        tbl.push_back(r(1, JL, 3'b000, 0, 0, 0, 1, O_FR));
        tbl.push_back(r(1, JL, 3'b000, 0, 0, 0, 0, O_DEC));
        tbl.push_back(r(1, JL, 3'b000, 0, 0, 0, 0, O_JAL));
        tbl.push_back(r(1, JL, 3'b000, 0, 0, 0, 0, O_AWB));
        tbl.push_back(r(1, RT, 3'b111, 0, 0, 0, 1, O_FR));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // slti: funct3 010 is unsupported
        step(r(1, RT, 3'b111, 0, 0, 0, 1, O_DEC), "and_dec");
        step(r(1, RT, 3'b111, 0, 0, 0, 1, exr(3'b111)), "and_exec");
        step(r(1, RT, 3'b111, 0, 0, 0, 1, O_AWB), "and_wb");
        step(r(1, IT, 3'b010, 0, 0, 0, 1, O_FR), "slti_fetch");
        step(r(1, IT, 3'b010, 0, 0, 0, 1, O_DEC), "slti_dec");
        @(posedge clk);
        #1;
        @(negedge clk);
        nchk++;
        if ({pcWrite, irWrite, regWrite, memRead, memWrite, illegal} !== 6'b0) begin
            nerr++;
            $display("FAIL slti_exec_strobes: got %b required 000000",
                     {pcWrite, irWrite, regWrite, memRead, memWrite, illegal});
        end
`ifdef RISKV_ILLEGAL_TRAP_EN
        step(r(1, IT, 3'b010, 0, 0, 0, 1, O_ILL), "slti_trap0");
        step(r(1, RT, 3'b000, 0, 0, 0, 1, O_ILL), "slti_trap1");
`else
        step(r(1, IT, 3'b010, 0, 0, 0, 1, O_FR), "slti_nop_fetch");
        step(r(1, IT, 3'b010, 0, 0, 0, 1, O_DEC), "slti_nop_dec");
`endif
        step(r(0, 7'd0, 3'b000, 0, 0, 0, 1, O_RST), "rst_a");

        // opcode 0000000
        step(r(1, 7'd0, 3'b000, 0, 0, 0, 1, O_FR), "op0_fetch");
        step(r(1, 7'd0, 3'b000, 0, 0, 0, 1, O_DEC), "op0_dec");
`ifdef RISKV_ILLEGAL_TRAP_EN
        step(r(1, 7'd0, 3'b000, 0, 0, 0, 1, O_ILL), "op0_trap0");
        step(r(1, LD, 3'b000, 0, 0, 0, 1, O_ILL), "op0_trap1");
        step(r(1, ST, 3'b000, 0, 0, 0, 1, O_ILL), "op0_trap2");
`else
        step(r(1, 7'd0, 3'b000, 0, 0, 0, 1, O_FR), "op0_nop_fetch");
        step(r(1, 7'd0, 3'b000, 0, 0, 0, 1, O_DEC), "op0_nop_dec");
`endif
        step(r(0, 7'd0, 3'b000, 0, 0, 0, 1, O_RST), "rst_b");

        // reset asserted mid-MEMWRITE stall
        step(r(1, ST, 3'b010, 0, 0, 0, 1, O_FR), "swr_fetch");
        step(r(1, ST, 3'b010, 0, 0, 0, 1, O_DEC), "swr_dec");
        step(r(1, ST, 3'b010, 0, 0, 0, 1, O_MA), "swr_adr");
        step(r(1, ST, 3'b010, 0, 0, 0, 0, O_MW), "swr_stall0");
        #2;
        rst_n = 1'b0;
        #1;
        check("swr_async_rst", O_RST);
        step(r(0, ST, 3'b010, 0, 0, 0, 0, O_RST), "swr_rst_hold");
        step(r(1, ST, 3'b010, 0, 0, 0, 0, O_FW), "swr_refetch");
        step(r(1, ST, 3'b010, 0, 0, 0, 1, O_FR), "swr_refetch_rdy");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
